tmr_alu_sequencer: RTL

Controller that sequences one operation at a time through the triple-modular-redundant ALU. It latches a request and holds the operands on the shared operand bus to all three ALU replicas. After a fixed settle time it samples the external ternary voter. It then returns the majority result, retries when there is no majority, and keeps per-replica saturating disagreement counters for fault diagnosis.

---
 rtl/tmr_alu_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tmr_alu_sequencer.sv
// Sequences one operation at a time through a triple-modular-redundant ALU:
// holds operands, samples the external voter, retries on no-majority, tracks per-replica faults.
module tmr_alu_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ALU_LAT   = 1,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [4:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res_a,
    input  logic [DATA_W-1:0] alu_res_b,
    input  logic [DATA_W-1:0] alu_res_c,
    input  logic [DATA_W-1:0] vote_out,
    input  logic              vote_error,
    input  logic              vote_invalid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_corrected,
    output logic              out_fault,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  err_cnt_a,
    output logic [CNT_W-1:0]  err_cnt_b,
    output logic [CNT_W-1:0]  err_cnt_c
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int WAIT_W  = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [1:0]         state_q, state_d;
    logic [4:0]         opcode_q, opcode_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               corrected_q, corrected_d;
    logic               fault_q, fault_d;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        wait_d      = wait_q;
        retry_d     = retry_q;
        result_d    = result_q;
        corrected_d = corrected_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opcode_d = in_opcode;
                    a_d      = in_a;
                    b_d      = in_b;
                    wait_d   = '0;
                    retry_d  = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wait_q == WAIT_W'(ALU_LAT - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_CHECK: begin
                if (!vote_invalid) begin
                    result_d    = vote_out;
                    corrected_d = vote_error;
                    fault_d     = 1'b0;
                    state_d     = S_RESP;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    wait_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    result_d    = vote_out;
                    corrected_d = 1'b0;
                    fault_d     = 1'b1;
                    state_d     = S_RESP;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wait_q      <= '0;
            retry_q     <= '0;
            result_q    <= '0;
            corrected_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wait_q      <= wait_d;
            retry_q     <= retry_d;
            result_q    <= result_d;
            corrected_q <= corrected_d;
            fault_q     <= fault_d;
        end
    end

    // Per-replica disagreement counters; a clear overrides a same-cycle increment.
    logic [DATA_W-1:0] res_arr [3];
    logic [CNT_W-1:0]  cnt_q [3];
    logic [CNT_W-1:0]  cnt_d [3];

    assign res_arr[0] = alu_res_a;
    assign res_arr[1] = alu_res_b;
    assign res_arr[2] = alu_res_c;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic inc;
            assign inc = (state_q == S_CHECK) && !vote_invalid && (res_arr[gi] != vote_out);

            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (cnt_clear) begin
                    cnt_d[gi] = '0;
                end else if (inc && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_RESP);
    assign alu_opcode    = opcode_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign out_result    = result_q;
    assign out_corrected = corrected_q;
    assign out_fault     = fault_q;
    assign err_cnt_a     = cnt_q[0];
    assign err_cnt_b     = cnt_q[1];
    assign err_cnt_c     = cnt_q[2];

endmodule
